// File: rtl/fib_bcd_display.sv
// Converts each new fibonacci result to BCD (sequential double-dabble) and
// drives a time-multiplexed, active-low seven-segment display.
module fib_bcd_display #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_result,
  output logic [4*NUM_DIGITS-1:0] bcd_digits,
  output logic                    out_valid,
  output logic                    busy,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int BW   = 4 * NUM_DIGITS;
  localparam int SRW  = BW + DATA_WIDTH;
  localparam int CNTW = $clog2(DATA_WIDTH + 1);
  localparam int RCW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_capture;
  logic                  w_shift;
  logic                  w_load;
  logic [SRW-1:0]        r_shift;
  logic [BW-1:0]         w_adj;
  logic [CNTW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_last_captured;
  logic                  r_last_valid;
  logic                  r_shown;
  logic [RCW-1:0]        r_refresh;
  logic [SW-1:0]         r_sel;
  logic [3:0]            w_digit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_capture) w_next_state = S_CONVERT;
      S_CONVERT: if (r_count == CNTW'(1)) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // A level-high valid with an unchanged result must not retrigger a conversion.
  always_comb begin
    w_capture = (r_state == S_IDLE) && in_valid &&
                (!r_last_valid || (in_result != r_last_captured));
    w_shift   = (r_state == S_CONVERT);
    w_load    = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_comb begin
    w_adj = r_shift[SRW-1 -: BW];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_adj[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_captured <= '0;
      r_last_valid    <= 1'b0;
      r_shift         <= '0;
      r_count         <= '0;
      bcd_digits      <= '0;
      out_valid       <= 1'b0;
      r_shown         <= 1'b0;
    end else if (w_capture) begin
      r_last_captured <= in_result;
      r_last_valid    <= 1'b1;
      r_shift         <= {{BW{1'b0}}, in_result};
      r_count         <= CNTW'(DATA_WIDTH);
      out_valid       <= 1'b0;
    end else if (w_shift) begin
      r_shift <= {w_adj, r_shift[DATA_WIDTH-1:0]} << 1;
      r_count <= r_count - CNTW'(1);
    end else if (w_load) begin
      bcd_digits <= r_shift[SRW-1 -: BW];
      out_valid  <= 1'b1;
      r_shown    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_sel     <= '0;
    end else if (r_refresh == RCW'(REFRESH_CYCLES - 1)) begin
      r_refresh <= '0;
      r_sel     <= (r_sel == SW'(NUM_DIGITS - 1)) ? '0 : r_sel + SW'(1);
    end else begin
      r_refresh <= r_refresh + RCW'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == SW'(i)) w_digit = bcd_digits[4*i +: 4];
    end
  end

  always_comb begin
    an_n  = ~(NUM_DIGITS'(1) << r_sel);
    seg_n = 7'h7F;
    if (r_shown) begin
      case (w_digit)
        4'd0:    seg_n = 7'h40;
        4'd1:    seg_n = 7'h79;
        4'd2:    seg_n = 7'h24;
        4'd3:    seg_n = 7'h30;
        4'd4:    seg_n = 7'h19;
        4'd5:    seg_n = 7'h12;
        4'd6:    seg_n = 7'h02;
        4'd7:    seg_n = 7'h78;
        4'd8:    seg_n = 7'h00;
        4'd9:    seg_n = 7'h10;
        default: seg_n = 7'h7F;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_display.sv
// Directed bench for fib_bcd_display: conversion table, latency, input-change,
// reset-abort and display-scan sequences.
module tb_fib_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_result;
  logic [11:0] bcd_digits;
  logic        out_valid;
  logic        busy;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;

  int n_vec = 0;
  int n_err = 0;

  fib_bcd_display #(.DATA_WIDTH(8), .NUM_DIGITS(3), .REFRESH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .bcd_digits(bcd_digits), .out_valid(out_valid), .busy(busy),
    .seg_n(seg_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] exp;
    bit          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges until out_valid is seen; 99 means it never came.
  task automatic wait_ov(input int start, output int k);
    k = 99;
    for (int c = start; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        k = c;
        return;
      end
    end
  endtask

  initial begin
    int          k;
    int          nb;
    int          sel;
    logic [11:0] prev;
    logic [6:0]  seg_tab[3];

    vecs[0]  = '{8'd1,   12'h001, 1'b0};
    vecs[1]  = '{8'd21,  12'h021, 1'b1};
    vecs[2]  = '{8'd255, 12'h255, 1'b0};
    vecs[3]  = '{8'd0,   12'h000, 1'b0};
    vecs[4]  = '{8'd34,  12'h034, 1'b0};
    vecs[5]  = '{8'd89,  12'h089, 1'b0};
    vecs[6]  = '{8'd144, 12'h144, 1'b0};
    vecs[7]  = '{8'd233, 12'h233, 1'b0};
    vecs[8]  = '{8'd99,  12'h099, 1'b0};
    vecs[9]  = '{8'd100, 12'h100, 1'b0};
    vecs[10] = '{8'd55,  12'h055, 1'b0};
    vecs[11] = '{8'd200, 12'h200, 1'b0};
    seg_tab[0] = 7'h79;
    seg_tab[1] = 7'h24;
    seg_tab[2] = 7'h40;

    rst = 1'b1; in_valid = 1'b0; in_result = 8'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bcd", 32'(bcd_digits), 32'h000);
    check("reset_seg", 32'(seg_n), 32'h7F);
    check("reset_an", 32'(an_n), 32'b110);

    prev = 12'h000;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_result = vecs[i].val;
      @(negedge clk);
      check("capture_busy", 32'(busy), 32'd1);
      check("capture_ov_low", 32'(out_valid), 32'd0);
      for (int c = 2; c <= 5; c++) @(negedge clk);
      check("hold_prev_digits", 32'(bcd_digits), 32'(prev));
      wait_ov(6, k);
      check("latency", 32'(k), 32'd10);
      check("busy_done", 32'(busy), 32'd0);
      check("digits", 32'(bcd_digits), 32'(vecs[i].exp));
      prev = vecs[i].exp;
      if (vecs[i].hold) begin
        nb = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (busy) nb++;
        end
        check("no_reconvert", 32'(nb), 32'd0);
      end
    end

    in_valid = 1'b0; in_result = 8'd77;
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("invalid_no_capture", 32'(nb), 32'd0);
    check("invalid_ov_kept", 32'(out_valid), 32'd1);
    check("invalid_digits_kept", 32'(bcd_digits), 32'h200);

    // Input changes mid-conversion: old value finishes, new one follows.
    in_valid = 1'b1; in_result = 8'd8;
    @(negedge clk);
    @(negedge clk); @(negedge clk);
    in_result = 8'd13;
    wait_ov(4, k);
    check("chg_latency", 32'(k), 32'd10);
    check("chg_first_digits", 32'(bcd_digits), 32'h008);
    check("chg_busy_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("chg_recapture", 32'(busy), 32'd1);
    wait_ov(2, k);
    check("chg_second_latency", 32'(k), 32'd10);
    check("chg_final_digits", 32'(bcd_digits), 32'h013);

    // Reset in the middle of a conversion.
    in_result = 8'd77;
    @(negedge clk);
    check("rst_case_capture", 32'(busy), 32'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ov", 32'(out_valid), 32'd0);
    check("rst_mid_bcd", 32'(bcd_digits), 32'h000);
    check("rst_mid_seg", 32'(seg_n), 32'h7F);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_an", 32'(an_n), 32'b110);
    @(negedge clk);
    rst = 1'b0;
    wait_ov(1, k);
    check("rst_recapture_latency", 32'(k), 32'd10);
    check("rst_recapture_digits", 32'(bcd_digits), 32'h077);

    // Display scan with known phase: counter and select restart at reset.
    rst = 1'b1; in_result = 8'd21;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 23; j++) begin
      @(negedge clk);
      if (j == 5) check("scan_blank_before_done", 32'(seg_n), 32'h7F);
      if (j == 10) check("scan_ov", 32'(out_valid), 32'd1);
      if (j >= 12) begin
        sel = (j / 4) % 3;
        check("scan_an", 32'(an_n), 32'(~(3'b001 << sel) & 3'b111));
        check("scan_seg", 32'(seg_n), 32'(seg_tab[sel]));
      end
    end
    check("scan_digits", 32'(bcd_digits), 32'h021);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
